// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer: latches the branch condition into the CON
// flip-flop, forms PC + sext(offset) and hands the control unit a one-cycle
// PC load / done handshake. Keeps saturating legal/taken branch statistics.
module branch_sequencer #(
    parameter int unsigned PC_W      = 32,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned OFF_W     = 19,
    parameter logic [4:0]  BR_OPCODE = 5'b10010
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [PC_W-1:0]  ir,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             con_in,
    output logic             busy,
    output logic             con_ff,
    output logic [PC_W-1:0]  pc_next,
    output logic             pc_load,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StTarget,
        StFinish
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e            state_q;
    logic [PC_W-1:0]   ir_q;
    logic [PC_W-1:0]   pc_q;
    logic              con_q;
    logic              busy_q;
    logic [PC_W-1:0]   pc_next_q;
    logic              pc_load_q;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  branch_q;
    logic [CNT_W-1:0]  taken_q;

    logic              legal;
    logic [PC_W-1:0]   offset_ext;
    logic [PC_W-1:0]   target;
    logic              taken;

    // Opcode decode and branch target from the captured instruction.
    always_comb begin
        legal      = (ir_q[PC_W-1 -: 5] == BR_OPCODE);
        offset_ext = {{(PC_W-OFF_W){ir_q[OFF_W-1]}}, ir_q[OFF_W-1:0]};
        target     = pc_q + offset_ext;  // modulo 2^PC_W, wrap is intentional
        taken      = legal & con_q;
    end

    // Sequencer FSM; every output is registered so FINISH strobes are glitch-free.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= StIdle;
            ir_q      <= '0;
            pc_q      <= '0;
            con_q     <= 1'b0;
            busy_q    <= 1'b0;
            pc_next_q <= '0;
            pc_load_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            branch_q  <= '0;
            taken_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        ir_q    <= ir;
                        pc_q    <= pc_in;
                        busy_q  <= 1'b1;
                        state_q <= StEval;
                    end
                end
                StEval: begin
                    con_q   <= legal & con_in;
                    state_q <= StTarget;
                end
                StTarget: begin
                    // The target feeds pc_next directly so it is visible in FINISH.
                    pc_next_q <= taken ? target : pc_q;
                    pc_load_q <= taken;
                    done_q    <= 1'b1;
                    err_q     <= ~legal;
                    if (legal && branch_q != CntMax) begin
                        branch_q <= branch_q + CntOne;
                    end
                    if (taken && taken_q != CntMax) begin
                        taken_q <= taken_q + CntOne;
                    end
                    state_q <= StFinish;
                end
                StFinish: begin
                    // start seen here is dropped; it is honoured next IDLE cycle.
                    pc_load_q <= 1'b0;
                    done_q    <= 1'b0;
                    err_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy         = busy_q;
    assign con_ff       = con_q;
    assign pc_next      = pc_next_q;
    assign pc_load      = pc_load_q;
    assign done         = done_q;
    assign err          = err_q;
    assign branch_count = branch_q;
    assign taken_count  = taken_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Randomized self-checking bench for branch_sequencer. A full-width instance
// and a 2-bit-counter instance share stimulus; expectations come from a
// transaction-level model (per-branch outcome, arithmetic target, saturation).
module tb_branch_sequencer;

    logic        clock = 1'b0;
    logic        clear_n;
    logic        start;
    logic [31:0] ir;
    logic [31:0] pc_in;
    logic        con_in;

    logic        busy, con_ff, pc_load, done, err;
    logic [31:0] pc_next;
    logic [15:0] branch_count, taken_count;

    logic        busy_s, con_ff_s, pc_load_s, done_s, err_s;
    logic [31:0] pc_next_s;
    logic [1:0]  branch_count_s, taken_count_s;

    always #5 clock = ~clock;

    branch_sequencer #(
        .PC_W  (32),
        .CNT_W (16),
        .OFF_W (19)
    ) dut (
        .clock        (clock),
        .clear_n      (clear_n),
        .start        (start),
        .ir           (ir),
        .pc_in        (pc_in),
        .con_in       (con_in),
        .busy         (busy),
        .con_ff       (con_ff),
        .pc_next      (pc_next),
        .pc_load      (pc_load),
        .done         (done),
        .err          (err),
        .branch_count (branch_count),
        .taken_count  (taken_count)
    );

    branch_sequencer #(
        .PC_W  (32),
        .CNT_W (2),
        .OFF_W (19)
    ) dut_s (
        .clock        (clock),
        .clear_n      (clear_n),
        .start        (start),
        .ir           (ir),
        .pc_in        (pc_in),
        .con_in       (con_in),
        .busy         (busy_s),
        .con_ff       (con_ff_s),
        .pc_next      (pc_next_s),
        .pc_load      (pc_load_s),
        .done         (done_s),
        .err          (err_s),
        .branch_count (branch_count_s),
        .taken_count  (taken_count_s)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: architectural view after each completed branch.
    int          m_branch, m_taken, m_branch_s, m_taken_s;
    logic        m_con;
    logic [31:0] m_pc_next;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    // PC + signed 19-bit offset, modulo 2^32.
    function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] irv);
        longint off;
        off = longint'(irv & 32'h0007_FFFF);
        if (off >= 262144) off -= 524288;
        return 32'(longint'(pc) + off);
    endfunction

    task automatic model_reset();
        m_branch   = 0;
        m_taken    = 0;
        m_branch_s = 0;
        m_taken_s  = 0;
        m_con      = 1'b0;
        m_pc_next  = '0;
    endtask

    task automatic check_all(input string tag, input logic eb, input logic ed,
                             input logic el, input logic ee);
        check_eq({tag, ".busy"},      busy,           eb);
        check_eq({tag, ".done"},      done,           ed);
        check_eq({tag, ".pc_load"},   pc_load,        el);
        check_eq({tag, ".err"},       err,            ee);
        check_eq({tag, ".con_ff"},    con_ff,         m_con);
        check_eq({tag, ".pc_next"},   pc_next,        m_pc_next);
        check_eq({tag, ".br_cnt"},    branch_count,   m_branch);
        check_eq({tag, ".tk_cnt"},    taken_count,    m_taken);
        check_eq({tag, ".s.busy"},    busy_s,         eb);
        check_eq({tag, ".s.done"},    done_s,         ed);
        check_eq({tag, ".s.pc_next"}, pc_next_s,      m_pc_next);
        check_eq({tag, ".s.br_cnt"},  branch_count_s, m_branch_s);
        check_eq({tag, ".s.tk_cnt"},  taken_count_s,  m_taken_s);
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge of the
    // first IDLE cycle after FINISH. con_in holds conv only in the EVAL cycle.
    task automatic run_branch(input logic [31:0] irv, input logic [31:0] pcv,
                              input logic conv, input bit hold);
        logic legal;
        legal = (irv[31:27] == 5'b10010);
        check_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        start  = 1'b1;
        ir     = irv;
        pc_in  = pcv;
        con_in = 1'($urandom);
        @(negedge clock);
        check_all("eval", 1'b1, 1'b0, 1'b0, 1'b0);
        start  = hold ? 1'b1 : 1'($urandom);
        ir     = $urandom;
        pc_in  = $urandom;
        con_in = conv;
        @(negedge clock);
        m_con = legal & conv;
        check_all("target", 1'b1, 1'b0, 1'b0, 1'b0);
        start  = hold ? 1'b1 : 1'($urandom);
        ir     = $urandom;
        pc_in  = $urandom;
        con_in = ~conv;
        @(negedge clock);
        if (legal) begin
            m_branch   = sat_inc(m_branch, 65535);
            m_branch_s = sat_inc(m_branch_s, 3);
            if (m_con) begin
                m_taken   = sat_inc(m_taken, 65535);
                m_taken_s = sat_inc(m_taken_s, 3);
            end
        end
        m_pc_next = (legal && m_con) ? ref_target(pcv, irv) : pcv;
        check_all("finish", 1'b1, 1'b1, legal & m_con, ~legal);
        start  = hold ? 1'b1 : 1'($urandom);
        con_in = 1'($urandom);
        @(negedge clock);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] irv;
        bit          hold;

        clear_n = 1'b0;
        start   = 1'b0;
        ir      = '0;
        pc_in   = '0;
        con_in  = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        clear_n = 1'b1;
        @(negedge clock);

        // Taken forward, not taken, negative wrap, illegal opcode.
        run_branch(32'h9000_0010, 32'h0000_0100, 1'b1, 1'b0);
        run_branch(32'h9000_0010, 32'h0000_0100, 1'b0, 1'b0);
        run_branch(32'h9007_FFFE, 32'h0000_0001, 1'b1, 1'b0);
        run_branch(32'h1800_0010, 32'h0000_0200, 1'b1, 1'b0);

        // start held high: done every 4th cycle; also drives small counters to 3.
        for (int i = 0; i < 5; i++) begin
            run_branch(32'h9000_0004 + 32'(i), 32'h0000_1000 * 32'(i + 1), 1'b1, 1'b1);
        end
        start = 1'b0;
        check_eq("sat.br_s", branch_count_s, 32'd3);
        check_eq("sat.tk_s", taken_count_s, 32'd3);

        // Reset asserted during TARGET abandons the branch.
        check_all("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        start  = 1'b1;
        ir     = 32'h9000_0010;
        pc_in  = 32'h0000_0100;
        @(negedge clock);
        start  = 1'b0;
        con_in = 1'b1;
        @(negedge clock);
        clear_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("rst_no_done", {31'd0, done | done_s | pc_load}, 32'd0);
            if (i == 1) clear_n = 1'b1;
        end
        check_all("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized branches.
        for (int n = 0; n < 200; n++) begin
            irv = $urandom;
            if ($urandom_range(0, 9) < 7) begin
                irv[31:27] = 5'b10010;
            end else if (irv[31:27] == 5'b10010) begin
                irv[27] = 1'b1;
            end
            rv   = $urandom;
            hold = ($urandom_range(0, 3) == 0);
            run_branch(irv, rv, 1'($urandom), hold);
            if (!hold) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
        end
        start = 1'b0;
        @(negedge clock);
        check_all("final", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Consumes the combinational branch-condition result (CON_in) and sequences the conditional-branch instruction to completion.
- Holds the CON flip-flop and computes the branch target, PC_next = PC + sext(C).
- Issues a one-cycle PC load and done handshake to the control unit.
- Keeps saturating taken/total branch statistics counters.
- Sits between the condition decoder / Ra bus and the PC register.

Parameters:
- PC_W, 32, width of PC and IR.
- CNT_W, 16, width of statistics counters.
- OFF_W, 19, width of branch offset field IR[OFF_W-1:0].
- BR_OPCODE, 5'b10010, opcode value in IR[31:27] identifying a conditional branch.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  control unit requests branch execution; sampled only in IDLE.
- ir  in  PC_W  instruction register value; sampled with start.
- pc_in  in  PC_W  already-incremented PC; sampled with start.
- con_in  in  1  condition result from the decoder; must be valid in the EVAL cycle.
- busy  out  1  high in every state except IDLE.
- con_ff  out  1  CON flip-flop.
- pc_next  out  PC_W  PC value to load.
- pc_load  out  1  one-cycle strobe: load pc_next into PC.
- done  out  1  one-cycle strobe: branch finished.
- err  out  1  one-cycle strobe with done: opcode was not BR_OPCODE.
- branch_count  out  CNT_W  number of legal branches completed.
- taken_count  out  CNT_W  number of legal branches taken.

Behaviour:
- Reset (clear_n=0, asynchronous): state=IDLE; all outputs 0; captured ir/pc registers 0. Takes effect mid-operation, abandoning the branch; no pc_load or done is issued.
- States: IDLE -> EVAL -> TARGET -> FINISH -> IDLE. Fixed latency: start high in cycle 0 gives done high in cycle 3.
- IDLE:
  - On start=1: capture ir into ir_q and pc_in into pc_q; go to EVAL.
  - start=0: stay in IDLE.
- EVAL:
  - Legal opcode (ir_q[31:27]==BR_OPCODE): con_ff <= con_in.
  - Illegal opcode: con_ff <= 0.
  - Go to TARGET.
- TARGET:
  - target <= pc_q + sign-extended ir_q[OFF_W-1:0] to PC_W bits.
  - Addition is modulo 2^PC_W, so wrap-around is silent.
  - Go to FINISH.
- FINISH (outputs registered; all strobes visible in this cycle only):
  - Illegal opcode: pc_next=pc_q, pc_load=0, done=1, err=1; counters unchanged.
  - Legal, con_ff=1: pc_next=target, pc_load=1, done=1; branch_count+1, taken_count+1.
  - Legal, con_ff=0: pc_next=pc_q, pc_load=0, done=1; branch_count+1.
  - Go to IDLE.
- start while busy=1: ignored, not queued. start in the same cycle as the FINISH->IDLE transition is ignored; it is accepted on the next IDLE cycle.
- con_in is sampled only in EVAL; changes in other cycles have no effect.
- con_ff holds its value until the next EVAL or reset.
- pc_next holds its last value after FINISH.
- Counters saturate at 2^CNT_W-1 and do not wrap. taken_count <= branch_count always.
- ir and pc_in changing after start has been accepted have no effect.

Test Plan:
- Reset mid-op: start, then clear_n low in the TARGET cycle -> all outputs 0, state IDLE; no done ever pulses for that branch.
- Taken forward: ir={10010,0000,0000,19'h00010}, pc_in=32'h100, con_in=1 in EVAL -> cycle 3: pc_load=1, pc_next=32'h110, done=1; taken_count=1, branch_count=1.
- Not taken: same ir, con_in=0 in EVAL and 1 in all other cycles -> pc_load=0, pc_next=32'h100, done=1; branch_count+1, taken_count unchanged.
- Negative offset with wrap: offset=19'h7FFFE (-2), pc_in=32'h1, con_in=1 -> pc_next=32'hFFFFFFFF.
- Illegal opcode: ir[31:27]=5'b00011, con_in=1 -> done=1, err=1, pc_load=0, con_ff=0; counters unchanged.
- Busy/saturation:
  - start held high continuously -> one branch completes every 4 cycles (done every 4th cycle).
  - CNT_W=2, 5 taken branches -> both counters stick at 3.
